// File: rtl/vx_execute_arb.sv
// Execute-unit arbiter: round-robin choice among requesters, held on one requester
// across multi-beat instructions and matrix groups, feeding one registered output stage.

module vx_execute_arb_chk (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    input  logic locked,
    input  logic win_sop
);
    // A beat accepted while no lock is held must start an instruction.
    sop_on_unlocked_accept: assert property (@(posedge clk) disable iff (reset)
        (fire && !locked) |-> win_sop);
endmodule

module vx_execute_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 256,
    parameter int SEL_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_sop,
    input  logic [NUM_INPUTS-1:0]       in_eop,
    input  logic [NUM_INPUTS-1:0]       in_mlock,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]        out_sel,
    input  logic                        out_ready
);
    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  lock_idx_q, lock_idx_d;
    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATAW-1:0]      out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;

    logic [NUM_INPUTS-1:0] grant_s;
    logic [SEL_WIDTH-1:0]  win_s;
    logic [SEL_WIDTH-1:0]  next_rr_s;
    logic [DATAW-1:0]      win_data_s;
    logic                  win_sop_s, win_eop_s, win_mlock_s;
    logic                  stage_free_s, fire_s, pick_s;
    int                    best_dist_s, dist_s;

    // Winner selection: the lock owner when locked, else nearest valid input at or after rr_ptr.
    always_comb begin
        grant_s     = '0;
        win_s       = '0;
        best_dist_s = NUM_INPUTS;
        dist_s      = 0;
        pick_s      = 1'b0;
        if (state_q == LOCKED) begin
            win_s = lock_idx_q;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                grant_s[i] = in_valid[i] && (i == int'(lock_idx_q));
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                dist_s      = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q))
                                                    : (i - int'(rr_ptr_q) + NUM_INPUTS);
                pick_s      = in_valid[i] && (dist_s < best_dist_s);
                best_dist_s = pick_s ? dist_s : best_dist_s;
                win_s       = pick_s ? SEL_WIDTH'(i) : win_s;
            end
            for (int i = 0; i < NUM_INPUTS; i++) begin
                grant_s[i] = (best_dist_s < NUM_INPUTS) && (int'(win_s) == i);
            end
        end
    end

    // Payload and framing bits of the granted requester.
    always_comb begin
        win_data_s  = '0;
        win_sop_s   = 1'b0;
        win_eop_s   = 1'b0;
        win_mlock_s = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            win_data_s  = win_data_s | (grant_s[i] ? in_data[i*DATAW +: DATAW] : {DATAW{1'b0}});
            win_sop_s   = win_sop_s   | (grant_s[i] & in_sop[i]);
            win_eop_s   = win_eop_s   | (grant_s[i] & in_eop[i]);
            win_mlock_s = win_mlock_s | (grant_s[i] & in_mlock[i]);
        end
    end

    assign stage_free_s = !out_valid_q || out_ready;
    assign in_ready     = (!reset && stage_free_s) ? grant_s : {NUM_INPUTS{1'b0}};
    assign fire_s       = !reset && stage_free_s && (|grant_s);
    assign next_rr_s    = (int'(win_s) == NUM_INPUTS - 1) ? {SEL_WIDTH{1'b0}}
                                                          : (win_s + SEL_WIDTH'(1));

    // Next-state: load the output stage on acceptance; lock until an eop without mlock.
    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (fire_s) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data_s;
            out_sel_d   = win_s;
            if (win_eop_s && !win_mlock_s) begin
                state_d  = UNLOCKED;
                rr_ptr_d = next_rr_s;
            end else begin
                state_d    = LOCKED;
                lock_idx_d = win_s;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output-stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNLOCKED;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

    vx_execute_arb_chk u_chk (
        .clk     (clk),
        .reset   (reset),
        .fire    (fire_s),
        .locked  (state_q == LOCKED),
        .win_sop (win_sop_s)
    );
endmodule

// File: tb/tb_vx_execute_arb.sv
// Directed bench for vx_execute_arb: per-cycle vectors with hand-computed grants and outputs
// (4 requesters, 16-bit payload = {2'b00, index, 4'h0, tag}).
module tb_vx_execute_arb;
    logic        clk;
    logic        reset;
    logic [3:0]  in_valid, in_sop, in_eop, in_mlock, in_ready;
    logic [63:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic [7:0]  tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] v, s, e, m;
        logic [7:0] tag;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] osel;
        logic [7:0] otag;
    } row_t;

    row_t rows[$];

    assign in_data = {8'h30, tag, 8'h20, tag, 8'h10, tag, 8'h00, tag};

    vx_execute_arb #(.NUM_INPUTS(4), .DATAW(16), .SEL_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_mlock  (in_mlock),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic rst, input logic [3:0] v, input logic [3:0] s,
                                input logic [3:0] e, input logic [3:0] m, input logic [7:0] tg,
                                input logic ordy, input logic [3:0] rdy, input logic ov,
                                input logic [1:0] osel, input logic [7:0] otag);
        row_t r;
        r.rst = rst; r.v = v; r.s = s; r.e = e; r.m = m; r.tag = tg;
        r.ordy = ordy; r.rdy = rdy; r.ov = ov; r.osel = osel; r.otag = otag;
        return r;
    endfunction

    function automatic logic [18:0] exp_word(input row_t r);
        return {r.ov, r.osel, 2'b00, r.osel, 4'h0, r.otag};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input row_t r);
        reset     = r.rst;
        in_valid  = r.v;
        in_sop    = r.s;
        in_eop    = r.e;
        in_mlock  = r.m;
        tag       = r.tag;
        out_ready = r.ordy;
    endtask

    task automatic apply_reset();
        apply_row(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00));
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_row(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 8'hEE, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00));
        step();
        step();
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b, expected 0000", in_ready);
        end
        n_checks++;
        if ({out_valid, out_sel, out_data} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got v=%b sel=%0d data=%h, expected all zero",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [18:0] exp_out;
        apply_reset();
        rows.delete();
        rows.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 8'h01, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01));
        rows.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 8'h02, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h02));
        rows.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 8'h03, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h03));
        rows.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 8'h04, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h04));
        rows.push_back(mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 8'h05, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h05));
        rows.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h06, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        foreach (rows[c]) begin
            apply_row(rows[c]);
            #1;
            n_checks++;
            if (in_ready !== rows[c].rdy) begin
                n_fail++;
                $display("FAIL rr in_ready[%0d]: got %b, expected %b", c, in_ready, rows[c].rdy);
            end
            step();
            exp_out = exp_word(rows[c]);
            n_checks++;
            if ((rows[c].ov || rows[c].rst) ? ({out_valid, out_sel, out_data} !== exp_out)
                                            : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL rr out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, exp_out[18], exp_out[17:16], exp_out[15:0]);
            end
        end
    endtask

    task automatic test_multibeat_lock();
        logic [18:0] exp_out;
        apply_reset();
        rows.delete();
        rows.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0, 8'h10, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10));
        rows.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'h0, 8'h11, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11));
        rows.push_back(mk(1'b0, 4'b0111, 4'b0111, 4'b0011, 4'h0, 8'h12, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12));
        rows.push_back(mk(1'b0, 4'b0111, 4'b0011, 4'b0011, 4'h0, 8'h13, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h13));
        rows.push_back(mk(1'b0, 4'b0111, 4'b0011, 4'b0111, 4'h0, 8'h14, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h14));
        rows.push_back(mk(1'b0, 4'b0011, 4'b0011, 4'b0011, 4'h0, 8'h15, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h15));
        rows.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'h0, 8'h16, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        foreach (rows[c]) begin
            apply_row(rows[c]);
            #1;
            n_checks++;
            if (in_ready !== rows[c].rdy) begin
                n_fail++;
                $display("FAIL lock3 in_ready[%0d]: got %b, expected %b", c, in_ready, rows[c].rdy);
            end
            step();
            exp_out = exp_word(rows[c]);
            n_checks++;
            if ((rows[c].ov || rows[c].rst) ? ({out_valid, out_sel, out_data} !== exp_out)
                                            : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL lock3 out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, exp_out[18], exp_out[17:16], exp_out[15:0]);
            end
        end
    endtask

    task automatic test_mlock_group();
        logic [18:0] exp_out;
        apply_reset();
        rows.delete();
        rows.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 8'h20, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h20));
        rows.push_back(mk(1'b0, 4'b1011, 4'b1011, 4'b1001, 4'b0000, 8'h21, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21));
        rows.push_back(mk(1'b0, 4'b1011, 4'b1001, 4'b1011, 4'b0000, 8'h22, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22));
        rows.push_back(mk(1'b0, 4'b0110, 4'b0110, 4'b0110, 4'b0000, 8'h23, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h23));
        rows.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h24, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        foreach (rows[c]) begin
            apply_row(rows[c]);
            #1;
            n_checks++;
            if (in_ready !== rows[c].rdy) begin
                n_fail++;
                $display("FAIL mlock in_ready[%0d]: got %b, expected %b", c, in_ready, rows[c].rdy);
            end
            step();
            exp_out = exp_word(rows[c]);
            n_checks++;
            if ((rows[c].ov || rows[c].rst) ? ({out_valid, out_sel, out_data} !== exp_out)
                                            : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL mlock out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, exp_out[18], exp_out[17:16], exp_out[15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] exp_out;
        apply_reset();
        rows.delete();
        rows.push_back(mk(1'b0, 4'b0001, 4'hF, 4'hF, 4'h0, 8'h30, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h30));
        rows.push_back(mk(1'b0, 4'b0011, 4'hF, 4'hF, 4'h0, 8'h31, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h30));
        rows.push_back(mk(1'b0, 4'b0011, 4'hF, 4'hF, 4'h0, 8'h32, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h30));
        rows.push_back(mk(1'b0, 4'b0011, 4'hF, 4'hF, 4'h0, 8'h33, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h30));
        rows.push_back(mk(1'b0, 4'b0011, 4'hF, 4'hF, 4'h0, 8'h34, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34));
        rows.push_back(mk(1'b0, 4'b0001, 4'hF, 4'hF, 4'h0, 8'h35, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h35));
        rows.push_back(mk(1'b0, 4'b0000, 4'hF, 4'hF, 4'h0, 8'h36, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        foreach (rows[c]) begin
            apply_row(rows[c]);
            #1;
            n_checks++;
            if (in_ready !== rows[c].rdy) begin
                n_fail++;
                $display("FAIL bp in_ready[%0d]: got %b, expected %b", c, in_ready, rows[c].rdy);
            end
            step();
            exp_out = exp_word(rows[c]);
            n_checks++;
            if ((rows[c].ov || rows[c].rst) ? ({out_valid, out_sel, out_data} !== exp_out)
                                            : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL bp out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, exp_out[18], exp_out[17:16], exp_out[15:0]);
            end
        end
    endtask

    task automatic test_lock_stall();
        logic [18:0] exp_out;
        apply_reset();
        rows.delete();
        rows.push_back(mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 4'h0, 8'h40, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h40));
        rows.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0, 8'h41, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        rows.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0, 8'h42, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        rows.push_back(mk(1'b0, 4'b1001, 4'b0001, 4'b0001, 4'h0, 8'h43, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h43));
        rows.push_back(mk(1'b0, 4'b1001, 4'b0001, 4'b1001, 4'h0, 8'h44, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
        rows.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'h0, 8'h45, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h45));
        rows.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'h0, 8'h46, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        foreach (rows[c]) begin
            apply_row(rows[c]);
            #1;
            n_checks++;
            if (in_ready !== rows[c].rdy) begin
                n_fail++;
                $display("FAIL stall in_ready[%0d]: got %b, expected %b", c, in_ready, rows[c].rdy);
            end
            step();
            exp_out = exp_word(rows[c]);
            n_checks++;
            if ((rows[c].ov || rows[c].rst) ? ({out_valid, out_sel, out_data} !== exp_out)
                                            : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL stall out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, exp_out[18], exp_out[17:16], exp_out[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [18:0] exp_out;
        apply_reset();
        rows.delete();
        rows.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'h0, 8'h50, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h50));
        rows.push_back(mk(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'h0, 8'h51, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h51));
        rows.push_back(mk(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'h0, 8'h52, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        rows.push_back(mk(1'b0, 4'b0101, 4'b0101, 4'b0101, 4'h0, 8'h53, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h53));
        rows.push_back(mk(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'h0, 8'h54, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h54));
        rows.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'h0, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
        foreach (rows[c]) begin
            apply_row(rows[c]);
            #1;
            n_checks++;
            if (in_ready !== rows[c].rdy) begin
                n_fail++;
                $display("FAIL rstlock in_ready[%0d]: got %b, expected %b", c, in_ready, rows[c].rdy);
            end
            step();
            exp_out = exp_word(rows[c]);
            n_checks++;
            if ((rows[c].ov || rows[c].rst) ? ({out_valid, out_sel, out_data} !== exp_out)
                                            : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL rstlock out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, exp_out[18], exp_out[17:16], exp_out[15:0]);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 4'h0;
        in_sop    = 4'h0;
        in_eop    = 4'h0;
        in_mlock  = 4'h0;
        tag       = 8'h00;
        out_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_multibeat_lock();
        test_mlock_group();
        test_backpressure();
        test_lock_stall();
        test_reset_mid_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
